// File: rtl/cpu_pio_pkg.sv
// Shared constants for the CPU input PIO: register addresses, edge-type
// encodings and the bus write qualifier.
package cpu_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic logic is_write(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/cpu_pio_debounce.sv
// Single-bit debounce filter: the output follows the input only after the
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module cpu_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Flip on the cycle the count would reach DEBOUNCE_CYCLES, so the added
    // latency is exactly DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_pio_in_irq.sv
// Avalon-MM input PIO with edge capture and maskable level IRQ.
// Optional input debouncing is enabled by defining CPU_PIO_IN_DEBOUNCE_EN.
module cpu_pio_in_irq
    import cpu_pio_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync0;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] wmask;
    logic [1:0]       arm_cnt;
    logic             armed;
    logic             wr_en;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign wmask        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign wr_en        = is_write(chipselect, write_n);
    assign armed        = (arm_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= in_port;
            sync1 <= sync0;
        end
    end

`ifdef CPU_PIO_IN_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        cpu_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (sync1[i]),
            .dout    (filt[i])
        );
    end
`else
    logic unused_cfg;
    assign unused_cfg = (DEBOUNCE_CYCLES < 1);
    assign filt       = sync1;
`endif

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_raw = filt & ~prev;
            EDGE_FALL: edge_raw = ~filt & prev;
            EDGE_ANY:  edge_raw = filt ^ prev;
            default:   edge_raw = '0;
        endcase
    end

    // Inputs already asserted at reset release would look like edges against
    // the cleared prev register; hold detection off until the pipeline fills.
    assign edge_det = armed ? edge_raw : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev    <= '0;
            arm_cnt <= '0;
        end else begin
            prev <= filt;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

    // A new edge always wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= wmask;
            end
            if (wr_en && address == ADDR_EDGECAP) begin
                edgecapture <= (edgecapture & ~wmask) | edge_det;
            end else begin
                edgecapture <= edgecapture | edge_det;
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = filt;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_cpu_pio_in_irq.sv
// Directed self-checking bench: three PIO instances (rising, falling, any
// edge) share one bus and one input port and are checked against hand values.
module tb_cpu_pio_in_irq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [2:0]  in_port;
    logic [31:0] rd_rise, rd_fall, rd_any;
    logic        irq_rise, irq_fall, irq_any;

    int checks   = 0;
    int failures = 0;

    cpu_pio_in_irq #(.WIDTH(3), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_rise), .irq(irq_rise)
    );

    cpu_pio_in_irq #(.WIDTH(3), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(16)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_fall), .irq(irq_fall)
    );

    cpu_pio_in_irq #(.WIDTH(3), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One bus write cycle; the write lands on the edge inside this task.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic readReg(input logic [1:0] addr);
        address = addr;
        tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 3'b111;
        tick();
        checkOutput("reset_rd", rd_any, 32'h0);
        checkOutput("reset_irq", {31'b0, irq_any}, 32'h0);
        tick();
        reset_n = 1'b1;

`ifdef CPU_PIO_IN_DEBOUNCE_EN
        in_port = 3'b000;
        ticks(5);
        address = 2'd0;
        in_port = 3'b010;
        ticks(10);
        in_port = 3'b000;
        ticks(30);
        checkOutput("db_glitch_data", rd_rise, 32'h0);
        readReg(2'd3);
        checkOutput("db_glitch_cap", rd_rise, 32'h0);
        readReg(2'd0);
        in_port = 3'b010;
        ticks(18);
        checkOutput("db_data_early", rd_rise, 32'h0);
        tick();
        checkOutput("db_data_18", rd_rise, 32'h2);
`else
        ticks(3);
        checkOutput("arm_data", rd_rise, 32'h7);
        checkOutput("arm_irq", {31'b0, irq_any}, 32'h0);
        readReg(2'd3);
        checkOutput("arm_cap_rise", rd_rise, 32'h0);
        checkOutput("arm_cap_any", rd_any, 32'h0);

        in_port = 3'b000;
        ticks(3);
        readReg(2'd3);
        checkOutput("fall_cap_rise", rd_rise, 32'h0);
        checkOutput("fall_cap_fall", rd_fall, 32'h7);
        checkOutput("fall_cap_any", rd_any, 32'h7);
        checkOutput("fall_irq_masked", {31'b0, irq_fall}, 32'h0);
        applyStimulus(2'd3, 32'h7);
        checkOutput("w1c_preclear_read", rd_fall, 32'h7);
        readReg(2'd3);
        checkOutput("w1c_cleared", rd_fall, 32'h0);

        applyStimulus(2'd2, 32'hFFFF_FFFA);
        readReg(2'd2);
        checkOutput("mask_read", rd_rise, 32'h2);

        in_port = 3'b010;
        ticks(2);
        checkOutput("irq_not_early", {31'b0, irq_rise}, 32'h0);
        tick();
        checkOutput("irq_rise_k2", {31'b0, irq_rise}, 32'h1);
        checkOutput("irq_any_k2", {31'b0, irq_any}, 32'h1);
        checkOutput("irq_fall_k2", {31'b0, irq_fall}, 32'h0);
        readReg(2'd0);
        checkOutput("data_010", rd_rise, 32'h2);
        readReg(2'd3);
        checkOutput("cap_rise_2", rd_rise, 32'h2);
        checkOutput("cap_fall_0", rd_fall, 32'h0);
        applyStimulus(2'd3, 32'h2);
        checkOutput("w1c_read_old", rd_rise, 32'h2);
        checkOutput("w1c_irq_clear", {31'b0, irq_rise}, 32'h0);

        in_port = 3'b011;
        ticks(2);
        applyStimulus(2'd3, 32'h1);
        readReg(2'd3);
        checkOutput("edge_beats_clr_rise", rd_rise, 32'h1);
        checkOutput("edge_beats_clr_any", rd_any, 32'h1);
        checkOutput("edge_beats_clr_fall", rd_fall, 32'h0);

        applyStimulus(2'd3, 32'h7);
        in_port = 3'b111;
        ticks(3);
        applyStimulus(2'd3, 32'h7);
        applyStimulus(2'd2, 32'h7);
        in_port = 3'b011;
        ticks(2);
        checkOutput("any_irq_not_early", {31'b0, irq_any}, 32'h0);
        tick();
        checkOutput("any_irq_fall_edge", {31'b0, irq_any}, 32'h1);
        checkOutput("fall_irq_fall_edge", {31'b0, irq_fall}, 32'h1);
        checkOutput("rise_irq_fall_edge", {31'b0, irq_rise}, 32'h0);
        readReg(2'd3);
        checkOutput("any_cap_4", rd_any, 32'h4);
        checkOutput("fall_cap_4", rd_fall, 32'h4);
        checkOutput("rise_cap_0", rd_rise, 32'h0);
        applyStimulus(2'd2, 32'h0);
        checkOutput("any_irq_mask0", {31'b0, irq_any}, 32'h0);
        readReg(2'd3);
        checkOutput("any_cap_kept", rd_any, 32'h4);

        applyStimulus(2'd1, 32'hFFFF_FFFF);
        readReg(2'd1);
        checkOutput("reserved_read", rd_any, 32'h0);
        applyStimulus(2'd0, 32'hFFFF_FFFF);
        readReg(2'd0);
        checkOutput("data_ro", rd_any, 32'h3);
        readReg(2'd2);
        checkOutput("mask_unchanged", rd_any, 32'h0);

        applyStimulus(2'd2, 32'h7);
        checkOutput("pre_reset_irq", {31'b0, irq_any}, 32'h1);
        readReg(2'd3);
        checkOutput("pre_reset_rd", rd_any, 32'h4);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_rd", rd_any, 32'h0);
        checkOutput("async_reset_irq", {31'b0, irq_any}, 32'h0);
        ticks(2);
        reset_n = 1'b1;
        ticks(5);
        readReg(2'd3);
        checkOutput("post_reset_cap_any", rd_any, 32'h0);
        checkOutput("post_reset_cap_rise", rd_rise, 32'h0);
        readReg(2'd2);
        checkOutput("post_reset_mask", rd_any, 32'h0);
        readReg(2'd0);
        checkOutput("post_reset_data", rd_any, 32'h3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_pio_in_irq.md
# cpu_pio_in_irq

Parametrised Avalon-MM input PIO slave for switch/sensor lines in the HPS sensor-memory CPU subsystem. It synchronises a WIDTH-bit input port, optionally debounces it, and detects edges into a sticky edge-capture register. A maskable level interrupt is raised to the CPU from the captured edges. It is the drop-in successor to the plain read-only input port: the register at address 0 is unchanged, and edge capture and IRQ are added.

## Interface
- WIDTH, 3: input port width, 1..32.
- EDGE_TYPE, 0: 0 rising, 1 falling, 2 any edge.
- DEBOUNCE_CYCLES, 16: stable cycles required before a filtered bit changes (used only with the debounce macro); must be ≥1.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select, qualifies writes.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH are ignored.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data, zero-extended.
- irq  out  1  level interrupt.

## Operation
- Register map:
  - 0 data (RO): filtered input value.
  - 1 reserved: reads 0, writes ignored.
  - 2 irqmask (RW).
  - 3 edgecapture (RO, write-1-to-clear per bit).
- Write condition: a write occurs when chipselect=1 and write_n=0. Writes to addresses 0 and 1 have no effect.
- Input path: in_port passes through a 2-flop synchroniser (sync0, sync1), then the optional filter, giving `filt`. `prev` holds `filt` delayed one cycle.
- Edge detection per bit:
  - rising: filt & ~prev
  - falling: ~filt & prev
  - any: filt ^ prev
- Edge capture:
  - edgecapture |= edge on every cycle.
  - A W1C write clears the addressed bits.
  - If a new edge and a W1C clear hit the same bit in the same cycle, the edge wins and the bit stays 1.
- IRQ: irq = |(edgecapture & irqmask), computed combinationally from registers.
- Arm counter:
  - A 2-bit saturating counter counts from 0 after reset release.
  - Edge detection is suppressed until the counter reaches 3.
  - This prevents false edges from inputs already asserted at reset.
- Reset (asynchronous, any time, including mid-debounce or with edges pending): sync regs, filt, prev, debounce counters, arm counter, irqmask, edgecapture, readdata and irq are all cleared to 0.

## Timing
- readdata:
  - Loaded every clock from the current address, regardless of chipselect.
  - Read latency is 1 cycle: address at edge k, data valid after edge k.
  - Reserved address returns 32'h0.
- Without debounce: an in_port change settling before edge k appears in data after edge k+2. edgecapture and irq are set after edge k+2 (edge is evaluated against prev within the same cycle).
- irqmask and W1C writes take effect after the writing edge. irq updates in the same cycle as the register change.
- A read of edgecapture in the same cycle as a W1C to it returns the pre-clear value.

## Configuration
- Macro: `CPU_PIO_IN_DEBOUNCE_EN`.
- Defined:
  - Each bit has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets to 0 whenever sync1 equals filt, and increments while they differ.
  - When the counter reaches DEBOUNCE_CYCLES, filt takes the sync1 value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach filt.
  - Added latency: DEBOUNCE_CYCLES cycles.
- Undefined: filt = sync1. No counters are built and no latency is added.

## Structure
- Package cpu_pio_pkg holds:
  - register address constants: ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3
  - edge type encodings: EDGE_RISE, EDGE_FALL, EDGE_ANY
- One sub-module, cpu_pio_debounce: a single-bit filter instantiated WIDTH times under the macro.

## Test plan
- Reset with in_port=3'b111 held, then release. After 3 cycles, data reads 32'h7, edgecapture reads 0 and irq=0.
- WIDTH=3, EDGE_TYPE=0, no debounce:
  - Write irqmask=3'b010.
  - Drive in_port 3'b000→3'b010 before edge k.
  - Expect edgecapture=2 and irq=1 after edge k+2.
  - Write 32'h2 to address 3: irq=0 after the next edge.
- Simultaneous clear and edge: W1C bit 0 in the same cycle a rising edge on bit 0 is detected. Expect edgecapture[0]=1.
- EDGE_TYPE=2, mask=3'b111: toggle bit 2 1→0. Expect edgecapture=4 and irq=1. With mask=0, irq stays 0 while edgecapture still reads 4.
- With debounce enabled, DEBOUNCE_CYCLES=16:
  - A 10-cycle pulse on bit 1 leaves data and edgecapture at 0.
  - A 20-cycle high level updates data to 2 exactly 18 cycles after the input change.
- Reset asserted mid-debounce with edgecapture=5 and irqmask=7: all outputs are 0 immediately, and there is no spurious edge after release.
